// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: command-level SPI master that frames RAM operations for the SPI slave/RAM wrapper
module spi_master_ctrl #(
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       seq_err,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_TURN, S_RECV, S_GAP} state_t;
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [9:0] w, w_d;
  logic [7:0] rx, rx_d, rsp_data_d;
  logic rd_seen, rd_seen_d, rsp_valid_d, seq_err_d, ss_n_d, mosi_d;
  wire is_rd = w[9:8] == 2'b11;
  assign cmd_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  // state, payload, receive shifter and registered pins; reset drops SS_n high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      w <= '0;
      rx <= '0;
      rd_seen <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      seq_err <= 1'b0;
      SS_n <= 1'b1;
      MOSI <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      w <= w_d;
      rx <= rx_d;
      rd_seen <= rd_seen_d;
      rsp_valid <= rsp_valid_d;
      rsp_data <= rsp_data_d;
      seq_err <= seq_err_d;
      SS_n <= ss_n_d;
      MOSI <= mosi_d;
    end
  end
  // frame sequencing; pins are computed from the next state so they leave flops
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    w_d = w;
    rx_d = rx;
    rd_seen_d = rd_seen;
    rsp_valid_d = 1'b0;
    rsp_data_d = rsp_data;
    seq_err_d = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) begin
        if (cmd_op == 2'b11 && !rd_seen) seq_err_d = 1'b1;
        else begin
          state_d = S_START;
          cnt_d = '0;
          w_d = {cmd_op, cmd_op == 2'b11 ? 8'h00 : cmd_data};
          rd_seen_d = rd_seen | (cmd_op == 2'b10);
        end
      end
      S_START: begin
        state_d = S_SHIFT;
        cnt_d = '0;
      end
      S_SHIFT: begin
        cnt_d = cnt == 4'd9 ? 4'd0 : cnt + 4'd1;
        if (cnt == 4'd9) state_d = !is_rd ? S_GAP : (TURNAROUND == 0 ? S_RECV : S_TURN);
      end
      S_TURN: begin
        cnt_d = cnt == TURN_LAST ? 4'd0 : cnt + 4'd1;
        if (cnt == TURN_LAST) state_d = S_RECV;
      end
      S_RECV: begin
        rx_d = {rx[6:0], MISO};
        cnt_d = cnt == 4'd7 ? 4'd0 : cnt + 4'd1;
        if (cnt == 4'd7) begin
          state_d = S_GAP;
          rsp_valid_d = 1'b1;
          rsp_data_d = {rx[6:0], MISO};
        end
      end
      S_GAP: begin
        cnt_d = cnt == GAP_LAST ? 4'd0 : cnt + 4'd1;
        if (cnt == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ss_n_d = !(state_d == S_START || state_d == S_SHIFT || state_d == S_TURN || state_d == S_RECV);
    mosi_d = (state_d == S_START || state_d == S_SHIFT) && w_d[4'd9 - cnt_d];
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed and random checks of spi_master_ctrl against a frame-level model
module tb_spi_master_ctrl;
  localparam int TA = 1;
  localparam int GP = 1;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, MISO = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, seq_err, busy, SS_n, MOSI;
  logic [7:0] rsp_data;
  int errors = 0, checks = 0;
  int cur_len = 0, high_len = 0, last_gap = 0, last_len = 0, frames = 0;
  int rsp_cnt = 0, err_cnt = 0, mosi_high = 0, tail_bad = 0, post_low = 0, ready_wait = -1;
  bit after_frame = 1'b0, seen = 1'b0;
  logic [10:0] cur_bits = '0, last_bits = '0;
  logic [7:0] slave_byte = '0, last_rsp = '0;

  spi_master_ctrl #(.TURNAROUND(TA), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .seq_err(seq_err), .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  // pin monitor and slave model: records frames from SS_n/MOSI, returns slave_byte during the receive window
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_len = 0;
      high_len = 0;
      after_frame = 1'b0;
    end else begin
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp = rsp_data;
      end
      if (seq_err) err_cnt++;
      if (!SS_n) begin
        if (cur_len == 0) begin
          last_gap = high_len;
          cur_bits = '0;
        end
        high_len = 0;
        if (cur_len < 11) cur_bits = {cur_bits[9:0], MOSI};
        else if (MOSI) tail_bad++;
        MISO = (cur_len >= 11 + TA && cur_len < 19 + TA) ? slave_byte[3'(7 - (cur_len - 11 - TA))] : 1'($urandom);
        cur_len++;
      end else begin
        if (MOSI) mosi_high++;
        if (cur_len > 0) begin
          frames++;
          last_len = cur_len;
          last_bits = cur_bits;
          cur_len = 0;
          after_frame = 1'b1;
          post_low = 0;
        end
        if (after_frame) begin
          if (cmd_ready) begin
            ready_wait = post_low;
            after_frame = 1'b0;
          end else post_low++;
        end
        high_len++;
        MISO = 1'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    chk("ready_timeout", 32'(cmd_ready), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 0);
  endtask

  // one command through the model: expected frame = {W[9], W}, W = {op, payload}
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] sb);
    int f0, r0, e0, el;
    bit exp_err;
    logic [9:0] w;
    exp_err = op == 2'b11 && !seen;
    if (op == 2'b10) seen = 1'b1;
    w = {op, op == 2'b11 ? 8'h00 : d};
    el = op == 2'b11 ? 19 + TA : 11;
    slave_byte = sb;
    wait_ready();
    f0 = frames; r0 = rsp_cnt; e0 = err_cnt;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 8'($urandom);
    wait_idle();
    repeat (2) @(negedge clk);
    #1;
    chk("seq_err_pulses", 32'(err_cnt - e0), exp_err ? 1 : 0);
    chk("frame_count", 32'(frames - f0), exp_err ? 0 : 1);
    chk("rsp_pulses", 32'(rsp_cnt - r0), (!exp_err && op == 2'b11) ? 1 : 0);
    if (!exp_err) begin
      chk("frame_len", 32'(last_len), 32'(el));
      chk("frame_bits", 32'(last_bits), 32'({w[9], w}));
      if (op == 2'b11) chk("rsp_data", 32'(last_rsp), 32'(sb));
    end
  endtask

  initial begin
    int f0, r0;
    repeat (3) @(negedge clk);
    chk("reset_state", {SS_n, MOSI, cmd_ready, busy, rsp_valid, seq_err, rsp_data}, {6'b101000, 8'h00});
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", {SS_n, MOSI, cmd_ready, rsp_valid, busy}, 5'b10100);
    end
    issue(2'b11, 8'h55, 8'h00);
    chk("seq_err_ready", 32'(cmd_ready), 1);
    issue(2'b00, 8'hA5, 8'h00);
    chk("wa_bits", 32'(last_bits), 32'(11'b00010100101));
    chk("ready_after_gap", 32'(ready_wait), GP);
    issue(2'b10, 8'h3C, 8'h00);
    issue(2'b11, 8'h00, 8'h96);
    chk("rd_bits", 32'(last_bits), 32'(11'b11100000000));
    chk("rd_len", 32'(last_len), 20);
    chk("rd_data", 32'(rsp_data), 32'h96);
    wait_ready();
    f0 = frames;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h10;
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    cmd_op = 2'b01; cmd_data = 8'hFF;
    wait_idle();
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_first_bits", 32'(last_bits), 32'(11'b00000010000));
    chk("b2b_first_len", 32'(last_len), 11);
    wait_idle();
    repeat (2) @(negedge clk);
    #1;
    chk("b2b_frames", 32'(frames - f0), 2);
    chk("b2b_second_bits", 32'(last_bits), 32'(11'b00111111111));
    chk("b2b_second_len", 32'(last_len), 11);
    chk("b2b_gap", 32'(last_gap), GP + 1);
    issue(2'b10, 8'h5A, 8'h00);
    slave_byte = 8'hC3;
    r0 = rsp_cnt;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (14 + TA) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_pins", {SS_n, MOSI, busy, cmd_ready}, 4'b1001);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_cnt - r0), 0);
    chk("abort_rsp_data", 32'(rsp_data), 0);
    issue(2'b11, 8'h00, 8'h00);
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(2'($urandom), 8'($urandom), 8'($urandom));
    end
    chk("mosi_while_ss_high", 32'(mosi_high), 0);
    chk("mosi_tail_zero", 32'(tail_bad), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
